alu_issue_unit: RTL and testbench

//   Execute-stage front end that drives the ALU. It accepts one RV32I instruction plus register

---
 rtl/alu_issue_unit.sv | 152 +++++++++++++++
 tb/tb_alu_issue_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// Execute-stage issue unit: decodes a small RV32I subset into ALU opcode/operands,
// waits one cycle for the combinational ALU, then returns the result over valid/ready.
`timescale 1ns/1ps

package alu_issue_pkg;
  localparam int ALU_OP_LENGTH = 4;
  typedef logic [ALU_OP_LENGTH-1:0] alu_op_t;
  localparam alu_op_t ALU_OP_ADD = 4'd0;
  localparam alu_op_t ALU_OP_SUB = 4'd1;
  localparam alu_op_t ALU_OP_AND = 4'd2;
endpackage

module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [XLEN-1:0]          rs1_val,
  input  logic [XLEN-1:0]          rs2_val,
  output logic [ALU_OP_LENGTH-1:0] alu_opcode,
  output logic [XLEN-1:0]          alu_left,
  output logic [XLEN-1:0]          alu_right,
  input  logic [XLEN-1:0]          alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_result,
  output logic [4:0]               out_rd,
  output logic                     out_illegal,
  output logic [CNT_WIDTH-1:0]     op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic            dec_legal;
  alu_op_t         dec_op;
  logic [XLEN-1:0] dec_right;
  logic            accept;
  logic            unused_rs_fields;

  assign opc              = instr[6:0];
  assign funct3           = instr[14:12];
  assign funct7           = instr[31:25];
  assign imm_i            = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign accept           = in_valid && in_ready;
  assign unused_rs_fields = ^instr[19:15];

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_OP_ADD;
    dec_right = rs2_val;
    unique case (opc)
      OPC_OP: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_op    = ALU_OP_ADD;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          dec_legal = 1'b1;
          dec_op    = ALU_OP_SUB;
        end else if (funct3 == 3'b111 && funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_op    = ALU_OP_AND;
        end
      end
      OPC_OP_IMM: begin
        dec_right = imm_i;
        if (funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = ALU_OP_ADD;
        end else if (funct3 == 3'b111) begin
          dec_legal = 1'b1;
          dec_op    = ALU_OP_AND;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = dec_legal ? EXEC : RESP;
      EXEC:    state_nxt = RESP;
      RESP:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == RESP);
  end

  // Illegal ops skip EXEC, so their zero result and flag are set at accept time.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_opcode  <= ALU_OP_ADD;
      alu_left    <= '0;
      alu_right   <= '0;
      out_result  <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
      op_count    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_opcode <= dec_op;
            alu_left   <= rs1_val;
            alu_right  <= dec_right;
            out_rd     <= instr[11:7];
            if (!dec_legal) begin
              out_illegal <= 1'b1;
              out_result  <= '0;
            end
          end
        end
        EXEC: begin
          out_result  <= alu_result;
          out_illegal <= 1'b0;
        end
        RESP: begin
          if (out_ready && !out_illegal) op_count <= op_count + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: stimulus pushes expected responses into a
// scoreboard queue; a negedge monitor pops and compares on every response handshake.
`timescale 1ns/1ps

module tb_alu_issue_unit;
  import alu_issue_pkg::*;

  localparam int XLEN      = 32;
  localparam int CNT_WIDTH = 32;

  logic                     clk;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              instr;
  logic [XLEN-1:0]          rs1_val;
  logic [XLEN-1:0]          rs2_val;
  logic [ALU_OP_LENGTH-1:0] alu_opcode;
  logic [XLEN-1:0]          alu_left;
  logic [XLEN-1:0]          alu_right;
  logic [XLEN-1:0]          alu_result;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_result;
  logic [4:0]               out_rd;
  logic                     out_illegal;
  logic [CNT_WIDTH-1:0]     op_count;

  alu_issue_unit #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .alu_opcode(alu_opcode), .alu_left(alu_left), .alu_right(alu_right),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal),
    .op_count(op_count)
  );

  // Stand-in for the external combinational ALU.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      ALU_OP_ADD: alu_result = alu_left + alu_right;
      ALU_OP_SUB: alu_result = alu_left - alu_right;
      ALU_OP_AND: alu_result = alu_left & alu_right;
      default:    alu_result = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        illegal;
  } resp_t;

  resp_t sb[$];
  int    n_vec     = 0;
  int    n_miss    = 0;
  int    exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: any response handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check("resp_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        resp_t r;
        r = sb.pop_front();
        check("resp_result",  out_result,  r.result);
        check("resp_rd",      out_rd,      r.rd);
        check("resp_illegal", out_illegal, r.illegal);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction, lets it be accepted, and checks latency to out_valid.
  task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_ill);
    resp_t r;
    in_valid = 1'b1;
    instr    = i;
    rs1_val  = a;
    rs2_val  = b;
    check("in_ready_idle", in_ready, 1);
    r.result  = exp_res;
    r.rd      = i[11:7];
    r.illegal = exp_ill;
    sb.push_back(r);
    step();
    in_valid = 1'b0;
    if (exp_ill) begin
      check("illegal_valid_t1", out_valid, 1);
    end else begin
      check("exec_no_valid", out_valid, 0);
      check("exec_in_ready", in_ready, 0);
      step();
      check("legal_valid_t2", out_valid, 1);
    end
  endtask

  // Completes the handshake (out_ready already high) and checks the retired count.
  task automatic finish_op(input logic legal);
    step();
    if (legal) exp_count++;
    check("op_count", op_count, exp_count);
    check("idle_after_resp", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    rs1_val   = '0;
    rs2_val   = '0;
    step();
    step();
    reset = 1'b0;

    check("rst_in_ready",    in_ready,    1);
    check("rst_out_valid",   out_valid,   0);
    check("rst_out_result",  out_result,  0);
    check("rst_out_rd",      out_rd,      0);
    check("rst_out_illegal", out_illegal, 0);
    check("rst_op_count",    op_count,    0);
    check("rst_alu_opcode",  alu_opcode,  ALU_OP_ADD);
    check("rst_alu_left",    alu_left,    0);
    check("rst_alu_right",   alu_right,   0);

    // ADD x5,x1,x2
    issue(32'h002082B3, 32'd4, 32'd3, 32'd7, 1'b0);
    check("add_opcode", alu_opcode, ALU_OP_ADD);
    check("add_left",   alu_left,   32'd4);
    check("add_right",  alu_right,  32'd3);
    finish_op(1'b1);

    // SUB x5,x1,x2, then an underflowing SUB
    issue(32'h402082B3, 32'd7, 32'd3, 32'd4, 1'b0);
    check("sub_opcode", alu_opcode, ALU_OP_SUB);
    finish_op(1'b1);
    issue(32'h402082B3, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);
    finish_op(1'b1);

    // ANDI x6,x1,-6
    issue(32'hFFA0F313, 32'h0000000C, 32'h12345678, 32'h00000008, 1'b0);
    check("andi_opcode", alu_opcode, ALU_OP_AND);
    check("andi_right",  alu_right,  32'hFFFFFFFA);
    finish_op(1'b1);

    // ADDI x1,x1,10 wrapping past 2^32; ADDI x1,x1,-1; AND x7,x1,x2
    issue(32'h00A08093, 32'hFFFFFFF8, 32'h0, 32'h00000002, 1'b0);
    finish_op(1'b1);
    issue(32'hFFF08093, 32'h0, 32'h5, 32'hFFFFFFFF, 1'b0);
    check("addi_neg_right", alu_right, 32'hFFFFFFFF);
    finish_op(1'b1);
    issue(32'h0020F3B3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
    finish_op(1'b1);

    // Illegal: all-zero word, OR (unsupported funct3), MUL (unsupported funct7)
    issue(32'h00000000, 32'h11, 32'h22, 32'h0, 1'b1);
    check("illegal_flag",   out_illegal, 1);
    check("illegal_result", out_result,  0);
    finish_op(1'b0);
    issue(32'h0020E3B3, 32'h11, 32'h22, 32'h0, 1'b1);
    finish_op(1'b0);
    issue(32'h022082B3, 32'h3, 32'h4, 32'h0, 1'b1);
    finish_op(1'b0);

    // Backpressure with a competing request held on in_valid
    out_ready = 1'b0;
    issue(32'h002082B3, 32'd10, 32'd20, 32'd30, 1'b0);
    in_valid = 1'b1;
    instr    = 32'h402082B3;
    rs1_val  = 32'd50;
    rs2_val  = 32'd8;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_in_ready",  in_ready,   0);
      check("bp_out_valid", out_valid,  1);
      check("bp_result",    out_result, 32'd30);
    end
    out_ready = 1'b1;
    step();
    exp_count++;
    check("bp_count",      op_count, exp_count);
    check("bp_ready_back", in_ready, 1);
    begin
      resp_t r;
      r.result  = 32'd42;
      r.rd      = 5'd5;
      r.illegal = 1'b0;
      sb.push_back(r);
    end
    step();
    in_valid = 1'b0;
    check("bp_next_accepted", in_ready, 0);
    step();
    check("bp_next_valid", out_valid, 1);
    finish_op(1'b1);

    // Reset while in EXEC drops the op with no response
    in_valid = 1'b1;
    instr    = 32'h002082B3;
    rs1_val  = 32'd1;
    rs2_val  = 32'd1;
    step();
    in_valid = 1'b0;
    check("rst_exec_state", in_ready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_count = 0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready",  in_ready,  1);
    check("midrst_op_count",  op_count,  0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("midrst_no_resp", out_valid, 0);
    end

    // Normal operation resumes after the reset
    issue(32'h002082B3, 32'd2, 32'd3, 32'd5, 1'b0);
    finish_op(1'b1);

    step();
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
